// File: rtl/pulse_train_gen_if.sv
// rtl/pulse_train_gen_if.sv - control/status bundle for pulse_train_gen (repeat_en present with PULSE_TRAIN_REPEAT_EN)
interface pulse_train_gen_if #(
    parameter int W  = 8,
    parameter int CW = 8
);
    logic          start;
    logic          stop;
    logic [W-1:0]  high_len;
    logic [W-1:0]  low_len;
    logic [CW-1:0] pulse_count;
`ifdef PULSE_TRAIN_REPEAT_EN
    logic          repeat_en;
`endif
    logic          pulse;
    logic          busy;
    logic          done;
    logic [CW-1:0] pulses_done;

    modport master (
        output start, stop, high_len, low_len, pulse_count,
`ifdef PULSE_TRAIN_REPEAT_EN
        output repeat_en,
`endif
        input  pulse, busy, done, pulses_done
    );

    modport slave (
        input  start, stop, high_len, low_len, pulse_count,
`ifdef PULSE_TRAIN_REPEAT_EN
        input  repeat_en,
`endif
        output pulse, busy, done, pulses_done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - clock-aligned programmable pulse-train generator
// Optional continuous-repeat mode is enabled by defining PULSE_TRAIN_REPEAT_EN.
module pulse_train_gen #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic               clock,
    input  logic               reset,
    pulse_train_gen_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  cnt, cnt_nxt;
    logic [W-1:0]  h_lat, h_nxt;
    logic [W-1:0]  l_lat, l_nxt;
    logic [CW-1:0] n_lat, n_nxt;
    logic [CW-1:0] pd_q, pd_nxt;
    logic [CW-1:0] pd_inc;
    logic          rep_lat, rep_nxt;
    logic          pulse_q, pulse_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;

    assign pd_inc = pd_q + CW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            h_lat   <= '0;
            l_lat   <= '0;
            n_lat   <= '0;
            pd_q    <= '0;
            rep_lat <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            h_lat   <= h_nxt;
            l_lat   <= l_nxt;
            n_lat   <= n_nxt;
            pd_q    <= pd_nxt;
            rep_lat <= rep_nxt;
            pulse_q <= pulse_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // cnt holds the number of cycles already spent in the current phase, including this one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        h_nxt     = h_lat;
        l_nxt     = l_lat;
        n_nxt     = n_lat;
        pd_nxt    = pd_q;
        rep_nxt   = rep_lat;
        pulse_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    h_nxt  = bus.high_len;
                    l_nxt  = (bus.low_len == '0) ? W'(1) : bus.low_len;
                    n_nxt  = bus.pulse_count;
                    pd_nxt = '0;
`ifdef PULSE_TRAIN_REPEAT_EN
                    rep_nxt = bus.repeat_en;
`else
                    rep_nxt = 1'b0;
`endif
                    if (bus.high_len == '0 || bus.pulse_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = W'(1);
                        pulse_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt == h_lat) begin
                    pd_nxt  = pd_inc;
                    cnt_nxt = W'(1);
                    if (pd_inc == n_lat && !rep_lat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOW;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt   = cnt + W'(1);
                    pulse_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            LOW: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (cnt == l_lat) begin
                    state_nxt = HIGH;
                    cnt_nxt   = W'(1);
                    pulse_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    // only reachable in repeat mode: the gap after the last pulse restarts the train
                    if (pd_q == n_lat)
                        pd_nxt = '0;
                end else begin
                    cnt_nxt  = cnt + W'(1);
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pulse       = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_done = pd_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - directed self-checking bench for pulse_train_gen
// Repeat-mode scenario is included when PULSE_TRAIN_REPEAT_EN is defined.
module tb_pulse_train_gen;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total;

    pulse_train_gen_if #(.W(8), .CW(8)) bus ();

    pulse_train_gen #(.W(8), .CW(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic bit exp_pulse(int c, int h, int l, int n);
        int p;
        p = h + ((l == 0) ? 1 : l);
        return (c / p < n) && (c % p < h);
    endfunction

    function automatic int end_cycle(int h, int l, int n);
        return (n - 1) * (h + ((l == 0) ? 1 : l)) + h;
    endfunction

    task automatic start_train(int h, int l, int n);
        bus.high_len    = 8'(h);
        bus.low_len     = 8'(l);
        bus.pulse_count = 8'(n);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pulses_done !== 8'd0)
            $display("FAIL reset: pulse=%b busy=%b done=%b pd=%0d, want 0 0 0 0", bus.pulse, bus.busy, bus.done, bus.pulses_done);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int e;
        e = end_cycle(3, 3, 4);
        start_train(3, 3, 4);
        for (int c = 0; c < 24; c++) begin
            total++;
            if (bus.pulse !== exp_pulse(c, 3, 3, 4) || bus.done !== (c == e) || bus.busy !== (c < e))
                $display("FAIL basic c%0d: pulse=%b done=%b busy=%b, want %b %b %b", c, bus.pulse, bus.done, bus.busy,
                         exp_pulse(c, 3, 3, 4), (c == e), (c < e));
            else pass_cnt++;
            if (c == e) begin
                total++;
                if (bus.pulses_done !== 8'd4) $display("FAIL basic_count: pd=%0d, want 4", bus.pulses_done);
                else pass_cnt++;
            end
            tick();
        end
    endtask

    task automatic test_low_zero;
        int e;
        e = end_cycle(1, 0, 3);
        start_train(1, 0, 3);
        for (int c = 0; c < 7; c++) begin
            total++;
            if (bus.pulse !== exp_pulse(c, 1, 0, 3) || bus.done !== (c == e))
                $display("FAIL low_zero c%0d: pulse=%b done=%b, want %b %b", c, bus.pulse, bus.done, exp_pulse(c, 1, 0, 3), (c == e));
            else pass_cnt++;
            tick();
        end
        total++;
        if (bus.pulses_done !== 8'd3) $display("FAIL low_zero_count: pd=%0d, want 3", bus.pulses_done);
        else pass_cnt++;
    endtask

    task automatic test_stop;
        start_train(5, 5, 10);
        for (int c = 0; c < 26; c++) begin
            total++;
            if (c < 23) begin
                if (bus.pulse !== exp_pulse(c, 5, 5, 10) || bus.done !== 1'b0 || bus.busy !== 1'b1)
                    $display("FAIL stop_run c%0d: pulse=%b done=%b busy=%b, want %b 0 1", c, bus.pulse, bus.done, bus.busy, exp_pulse(c, 5, 5, 10));
                else pass_cnt++;
            end else if (c == 23) begin
                if (bus.pulse !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pulses_done !== 8'd2)
                    $display("FAIL stop_end: pulse=%b done=%b busy=%b pd=%0d, want 0 1 0 2", bus.pulse, bus.done, bus.busy, bus.pulses_done);
                else pass_cnt++;
            end else begin
                if (bus.pulse !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0)
                    $display("FAIL stop_after c%0d: pulse=%b done=%b busy=%b, want 0 0 0", c, bus.pulse, bus.done, bus.busy);
                else pass_cnt++;
            end
            if (c == 3) begin
                bus.start       = 1'b1;
                bus.high_len    = 8'd1;
                bus.pulse_count = 8'd1;
            end
            if (c == 4) bus.start = 1'b0;
            bus.stop = (c == 22);
            tick();
        end
    endtask

    task automatic test_zero_len;
        start_train(0, 2, 3);
        total++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.pulses_done !== 8'd0)
            $display("FAIL zero_h: pulse=%b busy=%b done=%b pd=%0d, want 0 0 1 0", bus.pulse, bus.busy, bus.done, bus.pulses_done);
        else pass_cnt++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.pulse !== 1'b0) $display("FAIL zero_h_after: done=%b pulse=%b, want 0 0", bus.done, bus.pulse);
        else pass_cnt++;
        start_train(4, 2, 0);
        total++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1)
            $display("FAIL zero_n: pulse=%b busy=%b done=%b, want 0 0 1", bus.pulse, bus.busy, bus.done);
        else pass_cnt++;
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL zero_n_after: done=%b busy=%b, want 0 0", bus.done, bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_idle_stop;
        bus.high_len    = 8'd2;
        bus.low_len     = 8'd2;
        bus.pulse_count = 8'd2;
        bus.start       = 1'b1;
        bus.stop        = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.pulse !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL idle_stop: busy=%b pulse=%b done=%b, want 0 0 0", bus.busy, bus.pulse, bus.done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back;
        start_train(2, 1, 1);
        tick();
        tick();
        total++;
        if (bus.done !== 1'b1 || bus.pulse !== 1'b0 || bus.pulses_done !== 8'd1)
            $display("FAIL b2b_first_end: done=%b pulse=%b pd=%0d, want 1 0 1", bus.done, bus.pulse, bus.pulses_done);
        else pass_cnt++;
        start_train(1, 1, 2);
        total++;
        if (bus.pulse !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.pulses_done !== 8'd0)
            $display("FAIL b2b_second_start: pulse=%b busy=%b done=%b pd=%0d, want 1 1 0 0", bus.pulse, bus.busy, bus.done, bus.pulses_done);
        else pass_cnt++;
        tick();
        total++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b1) $display("FAIL b2b_gap: pulse=%b busy=%b, want 0 1", bus.pulse, bus.busy);
        else pass_cnt++;
        tick();
        total++;
        if (bus.pulse !== 1'b1) $display("FAIL b2b_second_pulse: pulse=%b, want 1", bus.pulse);
        else pass_cnt++;
        tick();
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pulses_done !== 8'd2)
            $display("FAIL b2b_second_end: done=%b busy=%b pd=%0d, want 1 0 2", bus.done, bus.busy, bus.pulses_done);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid;
        start_train(4, 2, 5);
        for (int c = 0; c < 7; c++) tick();
        total++;
        if (bus.pulse !== 1'b1 || bus.pulses_done !== 8'd1)
            $display("FAIL reset_mid_pre: pulse=%b pd=%0d, want 1 1", bus.pulse, bus.pulses_done);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (bus.pulse !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pulses_done !== 8'd0)
            $display("FAIL reset_mid: pulse=%b busy=%b done=%b pd=%0d, want 0 0 0 0", bus.pulse, bus.busy, bus.done, bus.pulses_done);
        else pass_cnt++;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_mid_after: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        else pass_cnt++;
    endtask

`ifdef PULSE_TRAIN_REPEAT_EN
    task automatic test_repeat;
        bus.repeat_en = 1'b1;
        start_train(2, 2, 2);
        bus.repeat_en = 1'b0;
        for (int c = 0; c < 16; c++) begin
            total++;
            if (bus.pulse !== (c % 4 < 2) || bus.done !== 1'b0 || bus.busy !== 1'b1)
                $display("FAIL repeat c%0d: pulse=%b done=%b busy=%b, want %b 0 1", c, bus.pulse, bus.done, bus.busy, (c % 4 < 2));
            else pass_cnt++;
            if (c == 7 || c == 9) begin
                total++;
                if (bus.pulses_done !== ((c == 7) ? 8'd2 : 8'd0))
                    $display("FAIL repeat_count c%0d: pd=%0d, want %0d", c, bus.pulses_done, (c == 7) ? 2 : 0);
                else pass_cnt++;
            end
            bus.stop = (c == 15);
            tick();
        end
        bus.stop = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pulse !== 1'b0)
            $display("FAIL repeat_stop: done=%b busy=%b pulse=%b, want 1 0 0", bus.done, bus.busy, bus.pulse);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        pass_cnt        = 0;
        total           = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.high_len    = '0;
        bus.low_len     = '0;
        bus.pulse_count = '0;
`ifdef PULSE_TRAIN_REPEAT_EN
        bus.repeat_en   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_low_zero();
        test_stop();
        test_zero_len();
        test_idle_stop();
        test_back_to_back();
        test_reset_mid();
`ifdef PULSE_TRAIN_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Synchronous, parametrised pulse-train generator that emits a programmable number of pulses with programmable high and low times on a single registered output. It is the clocked successor of the team's fixed four-pulses-per-clock generator: every pulse edge is aligned to `clock` rather than to simulation delays. It sits beside the shared `clock` source in the Guia benches and drives waveform or stimulus inputs of downstream blocks.

## Interface
- `W`, 8: width of `high_len` / `low_len` and the internal phase counter.
- `CW`, 8: width of `pulse_count` and `pulses_done`.

- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a train; sampled only in IDLE.
- `stop` in 1: abort the running train; sampled every cycle.
- `high_len` in W: pulse high time in cycles; latched on accepted `start`.
- `low_len` in W: gap low time in cycles; latched on accepted `start`; 0 is treated as 1.
- `pulse_count` in CW: number of pulses; latched on accepted `start`.
- `pulse` out 1: registered pulse output.
- `busy` out 1: high while a train is running.
- `done` out 1: one-cycle strobe at train end (normal or aborted).
- `pulses_done` out CW: pulses fully completed in the current/last train; holds after completion.

## Operation
- States: IDLE, HIGH, LOW.
- IDLE: `pulse`=0, `busy`=0. When `start`=1 and `stop`=0, latch `high_len`, `low_len`, `pulse_count`, clear `pulses_done`:
  - If latched `high_len`=0 or `pulse_count`=0, stay IDLE and assert `done` for one cycle; no pulse.
  - Otherwise go to HIGH with `pulse`=1, `busy`=1.
- HIGH: hold `pulse`=1 for exactly `high_len` cycles. On leaving, increment `pulses_done`. If `pulses_done+1` = `pulse_count`, go to IDLE with `done`=1; else go to LOW.
- LOW: hold `pulse`=0 for max(`low_len`,1) cycles, then go to HIGH.
- `start` while busy is ignored. Input changes on `high_len`/`low_len`/`pulse_count` while busy have no effect.
- `stop`=1 in HIGH or LOW: next edge goes to IDLE, `pulse`=0, `busy`=0, `done`=1; `pulses_done` holds its current value (a truncated pulse is not counted). `stop` in IDLE is ignored and blocks a simultaneous `start`.
- Counters: phase counter W bits, pulse counter CW bits, both compared by equality; no wrap occurs because the limits are latched.

## Timing
- Reset: `pulse`=0, `busy`=0, `done`=0, `pulses_done`=0, state IDLE; reset overrides `start`/`stop` and aborts a running train without a `done` strobe.
- Cycle n denotes the interval after rising edge n; `start` sampled at edge 0.
- Pulse k (k=0..N−1) is high in cycles k·(H+L') … k·(H+L')+H−1, with L'=max(L,1).
- End of train: at edge (N−1)·(H+L')+H, `pulse`=0, `busy`=0, `done`=1 for that one cycle.
- A new `start` is accepted in the cycle `done` is high (state is IDLE); back-to-back trains have no extra gap.
- Outputs are all registered; no combinational path from inputs to outputs.

## Configuration
- `PULSE_TRAIN_REPEAT_EN`: when defined, adds input `repeat_en` (1 bit, latched on `start`). With `repeat_en`=1, after the last pulse the block inserts a normal L' gap and restarts the train with the latched values, clearing `pulses_done`; `done` is raised only on `stop`. Without the macro the port does not exist and every train is one-shot.

## Test plan
- Reset mid-train (H=4,L=2,N=5, reset at cycle 7) -> next cycle `pulse`=0, `busy`=0, `done`=0, `pulses_done`=0.
- H=3,L=3,N=4, start at edge 0 -> `pulse` high cycles 0–2,6–8,12–14,18–20; `done`=1 only in cycle 21; `pulses_done`=4.
- H=1,L=0,N=3 -> pulses in cycles 0,2,4 (L treated as 1); `done` in cycle 5.
- H=0 or N=0 with start -> `pulse` stays 0, `busy` stays 0, `done`=1 for one cycle.
- H=5,L=5,N=10, stop at edge 23 -> `pulse`=0 from cycle 23, `done`=1 in cycle 23, `pulses_done`=2; start raised at edge 4 during train ignored.
- With `PULSE_TRAIN_REPEAT_EN`, `repeat_en`=1, H=2,L=2,N=2 -> period-4 pulses continue past cycle 8 with no `done`; stop -> `done` strobe, `busy`=0.
